// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor c = a - b.
// Handles subnormals, RNE rounding, overflow to infinity and NaN/inf operands.
module fp_sub_seq #(
    parameter logic [31:0] QNAN  = 32'h7FC0_0000,
    parameter int          MAXSH = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [32:1] a,
    input  logic [32:1] b,
    output logic        busy,
    output logic        done,
    output logic [32:1] c
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [9:0] MAXSH_W  = 10'(MAXSH);

    logic [2:0]  state;
    logic [32:1] opa, opb;       // opb holds -b
    logic        xs, ys;
    logic [9:0]  e, ye;          // e is X's exponent, later the working exponent
    logic [26:0] m, ym;          // {mantissa, G, R, S}
    logic [31:0] res;

    // operand classification and magnitude ordering
    logic        a_nan, b_nan, a_inf, b_inf, a_big;
    logic [7:0]  a_ee, b_ee;
    logic [23:0] a_m, b_m;
    assign a_nan = (opa[31:24] == 8'hFF) && (opa[23:1] != '0);
    assign b_nan = (opb[31:24] == 8'hFF) && (opb[23:1] != '0);
    assign a_inf = (opa[31:24] == 8'hFF) && (opa[23:1] == '0);
    assign b_inf = (opb[31:24] == 8'hFF) && (opb[23:1] == '0);
    assign a_ee  = (opa[31:24] == 8'd0) ? 8'd1 : opa[31:24];
    assign b_ee  = (opb[31:24] == 8'd0) ? 8'd1 : opb[31:24];
    assign a_m   = {(opa[31:24] != 8'd0), opa[23:1]};
    assign b_m   = {(opb[31:24] != 8'd0), opb[23:1]};
    assign a_big = {a_ee, a_m} >= {b_ee, b_m};

    // alignment: everything shifted past the S position folds into sticky
    logic [9:0]  dexp;
    logic [4:0]  sh;
    logic [53:0] ysh;
    logic [26:0] yal;
    assign dexp = e - ye;
    assign sh   = (dexp >= MAXSH_W) ? MAXSH_W[4:0] : dexp[4:0];
    assign ysh  = {ym, 27'd0} >> sh;
    assign yal  = {ysh[53:28], ysh[27] | (|ysh[26:0])};

    logic [27:0] sum;
    assign sum = (xs == ys) ? ({1'b0, m} + {1'b0, ym}) : ({1'b0, m} - {1'b0, ym});

    // round to nearest even on {G,R,S}
    logic        rinc;
    logic [24:0] mr;
    logic [23:0] mf;
    logic [9:0]  er;
    logic [31:0] rnd;
    assign rinc = m[2] & (m[1] | m[0] | m[3]);
    assign mr   = {1'b0, m[26:3]} + {24'd0, rinc};
    assign mf   = mr[24] ? mr[24:1] : mr[23:0];
    assign er   = e + {9'd0, mr[24]};

    always_comb begin
        rnd = {xs, (mf[23] ? er[7:0] : 8'd0), mf[22:0]};
        if (er >= 10'd255)
            rnd = {xs, 8'hFF, 23'd0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            c     <= '0;
            opa   <= '0;
            opb   <= '0;
            xs    <= 1'b0;
            ys    <= 1'b0;
            e     <= '0;
            ye    <= '0;
            m     <= '0;
            ym    <= '0;
            res   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= {~b[32], b[31:1]};
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (a_nan || b_nan || (a_inf && b_inf && (opa[32] != opb[32]))) begin
                        res   <= QNAN;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (a_inf || b_inf) begin
                        res   <= {(a_inf ? opa[32] : opb[32]), 8'hFF, 23'd0};
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        xs    <= a_big ? opa[32] : opb[32];
                        ys    <= a_big ? opb[32] : opa[32];
                        e     <= {2'b0, (a_big ? a_ee : b_ee)};
                        ye    <= {2'b0, (a_big ? b_ee : a_ee)};
                        m     <= {(a_big ? a_m : b_m), 3'b000};
                        ym    <= {(a_big ? b_m : a_m), 3'b000};
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    ym    <= yal;
                    state <= S_ADD;
                end
                S_ADD: begin
                    if (sum == '0) begin
                        // only -0 + -0 keeps a negative sign
                        res   <= {(xs & ys), 31'd0};
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (sum[27]) begin
                        m     <= {sum[27:2], sum[1] | sum[0]};
                        e     <= e + 10'd1;
                        state <= S_ROUND;
                    end else begin
                        m     <= sum[26:0];
                        state <= (sum[26] || (e <= 10'd1)) ? S_ROUND : S_NORM;
                    end
                end
                S_NORM: begin
                    m     <= {m[25:0], 1'b0};
                    e     <= e - 10'd1;
                    state <= (m[25] || (e <= 10'd2)) ? S_ROUND : S_NORM;
                end
                S_ROUND: begin
                    res   <= rnd;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    c     <= res;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: results, start-to-done latency, busy/done
// handshake, back-to-back starts and mid-operation reset.
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [32:1] a, b;
    logic        busy, done;
    logic [32:1] c;

    int ncmp = 0;
    int nerr = 0;

    fp_sub_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where done is seen.
    task automatic op(input logic [31:0] av, input logic [31:0] bv,
                      output logic [31:0] cv, output int lat, output int bcnt);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 999;
        bcnt  = busy ? 1 : 0;
        cv    = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                cv  = c;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    logic [31:0] r;
    int          lat, bc, pulses;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_c", c, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 12 - 2 = 10
        op(32'h4140_0000, 32'h4000_0000, r, lat, bc);
        chk("c1_c", r, 32'h4120_0000);
        chk("c1_lat", 32'(lat), 32'd5);
        chk("c1_busy", 32'(bc), 32'd4);
        @(posedge clk); #1;
        chk("c1_pulse", 32'(done), 32'd0);
        chk("c1_hold", c, 32'h4120_0000);

        // x - x = +0, then back-to-back (-0) - (+0) = -0
        op(32'h4000_0000, 32'h4000_0000, r, lat, bc);
        chk("zero_c", r, 32'h0000_0000);
        chk("zero_lat", 32'(lat), 32'd4);
        op(32'h8000_0000, 32'h0000_0000, r, lat, bc);
        chk("negz_c", r, 32'h8000_0000);
        chk("negz_lat", 32'(lat), 32'd4);

        // 23-step normalisation
        op(32'h3F80_0001, 32'h3F80_0000, r, lat, bc);
        chk("c3_c", r, 32'h3400_0000);
        chk("c3_lat", 32'(lat), 32'd28);

        // 1 - 2^-25: tie, odd LSB, rounds up with mantissa overflow
        op(32'h3F80_0000, 32'h3300_0000, r, lat, bc);
        chk("rne_c", r, 32'h3F80_0000);
        chk("rne_lat", 32'(lat), 32'd6);

        // 2^24 - 1 exact
        op(32'h4B80_0000, 32'h3F80_0000, r, lat, bc);
        chk("p24_c", r, 32'h4B7F_FFFF);

        // subnormal result
        op(32'h0000_0003, 32'h0000_0001, r, lat, bc);
        chk("sub_c", r, 32'h0000_0002);
        chk("sub_lat", 32'(lat), 32'd5);

        // specials
        op(32'h7F80_0000, 32'h7F80_0000, r, lat, bc);
        chk("infinf_c", r, 32'h7FC0_0000);
        chk("infinf_lat", 32'(lat), 32'd2);
        op(32'h7F80_0001, 32'h3F80_0000, r, lat, bc);
        chk("nan_c", r, 32'h7FC0_0000);
        op(32'h3F80_0000, 32'h7F80_0000, r, lat, bc);
        chk("fin_minus_inf", r, 32'hFF80_0000);
        chk("fin_minus_inf_lat", 32'(lat), 32'd2);

        // overflow to +inf
        op(32'h7F7F_FFFF, 32'hFF7F_FFFF, r, lat, bc);
        chk("ovf_c", r, 32'h7F80_0000);
        chk("ovf_lat", 32'(lat), 32'd5);

        // reset during NORM aborts without a done pulse
        start = 1'b1; a = 32'h3F80_0001; b = 32'h3F80_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_c", c, 32'h0);
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_nopulse", 32'(pulses), 32'd0);
        op(32'h4140_0000, 32'h4000_0000, r, lat, bc);
        chk("after_abort_c", r, 32'h4120_0000);
        chk("after_abort_lat", 32'(lat), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/fp_sub_seq.md
Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor, c = a − b, driven by an explicit state machine with a start/busy/done handshake.
- Sits beside the pipelined adder in the FPA datapath and provides the subtract direction.
- Adds what the adder path lacks:
  - subnormal inputs and outputs;
  - round-to-nearest-even (RNE) using guard/round/sticky bits;
  - overflow to infinity;
  - full NaN and infinity handling.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for every NaN result.
- MAXSH, 27, alignment shift saturation limit; all shifted-out bits collapse into sticky.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  32 [32:1]  minuend; bit 32 sign, [31:24] exponent, [23:1] fraction.
- b  in  32 [32:1]  subtrahend; same layout.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when c is valid.
- c  out  32 [32:1]  result; registered and held until the next done or reset.

Behaviour:
- Reset: one clock, synchronous, active-high; clk/rst only. Under rst: state=IDLE, busy=0, done=0, c=0, internal registers cleared. rst mid-operation aborts the operation; no done pulse is produced.
- States: IDLE → UNPACK → ALIGN → ADD → [NORM]* → ROUND → DONE → IDLE.
- IDLE: on start=1, capture a and b; b sign inverted (subtract = add of −b). start while busy is ignored.
- UNPACK (1 cycle):
  - hidden bit = (exp != 0); exp 0 is treated as 1 (subnormals);
  - operands swapped so X has the larger magnitude (exp, then fraction);
  - specials go directly to DONE:
    - any NaN → QNAN;
    - inf − inf with the same sign → QNAN;
    - otherwise inf → inf carrying the effective sign.
- ALIGN (1 cycle): Y mantissa (24b + G,R,S) shifted right by expX − expY, saturated at MAXSH; sticky = OR of all dropped bits.
- ADD (1 cycle), 28-bit datapath:
  - effective add if signs are equal, else X − Y;
  - carry out → shift right 1 (sticky kept), exp+1;
  - exact zero result → DONE with c = +0, except (−0) − (+0) = −0.
- NORM: while leading bit = 0 and exp > 1, shift left 1 and decrement exp, one bit per cycle. Stops at exp = 1, giving a subnormal.
- ROUND (1 cycle):
  - RNE: increment if G & (R | S | LSB);
  - mantissa overflow → exp+1;
  - exp ≥ 255 → ±inf (fraction 0);
  - leading bit 0 → exponent field 0;
  - sign = sign of X.
- DONE (1 cycle): c register loaded, done=1, busy=0 next cycle.
- Latency, counted in edges from the start-sampling edge to the edge at which done goes high:
  - normal path: 5+k (k = NORM shifts);
  - zero result: 4;
  - special operands: 2.
- Back-to-back: start may be asserted in the cycle done is high; it is accepted because state returns to IDLE on that edge, and the next edge samples it.

Test Plan:
- a=0x4140_0000 (12), b=0x4000_0000 (2), start pulse → c=0x4120_0000 (10), done 5 edges after start, busy high 4 cycles.
- a=b=0x4000_0000 → c=0x0000_0000, done at edge 4. a=0x8000_0000, b=0x0000_0000 → c=0x8000_0000.
- a=0x3F80_0001, b=0x3F80_0000 → c=0x3400_0000 (2^-23), k=23, done at edge 28.
- a=0x3F80_0000, b=0x3300_0000 (2^-25) → RNE tie rounds up with mantissa overflow → c=0x3F80_0000.
- a=b=0x7F80_0000 → c=0x7FC0_0000 at edge 2. a=0x7F7F_FFFF, b=0xFF7F_FFFF → c=0x7F80_0000 (overflow).
- Start case 3, assert rst for 1 cycle during NORM → next cycle busy=0, done=0, c=0; no done pulse. Then a new start of case 1 → c=0x4120_0000.
